// File: rtl/system_0_sysid_pkg.sv
// Shared types and defaults for the sysid checker: FSM encoding, expected
// sysid contents and the stall-counter width.
package system_0_sysid_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdId,
      StRdTs,
      StCmp,
      StFin
   } sysid_state_e;

   localparam logic [31:0] DefaultExpectedId = 32'd0;
   localparam logic [31:0] DefaultExpectedTs = 32'd1671495253;
   localparam int unsigned StallWidth        = 16;

   function automatic logic is_read_state(input sysid_state_e s);
      return (s == StRdId) || (s == StRdTs);
   endfunction

endpackage

// File: rtl/system_0_stall_timer.sv
// Counts stalled cycles of one Avalon read; flags the cycle that would be the
// LIMIT-th consecutive stall so the caller can abort on that edge.
module system_0_stall_timer
   import system_0_sysid_pkg::*;
#(
   parameter int unsigned LIMIT = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic stall,
   output logic expired
);

   localparam logic [StallWidth-1:0] LastCount = 16'(LIMIT - 32'd1);

   logic [StallWidth-1:0] count_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (stall) begin
         count_q <= count_q + 16'd1;
      end
   end

   // count_q holds the stalls already seen, so this cycle is stall number count_q+1
   assign expired = stall && (count_q == LastCount);

endmodule

// File: rtl/system_0_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM after reset or on a
// start pulse, compares them to the expected build values and reports the result.
module system_0_sysid_checker
   import system_0_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = DefaultExpectedId,
   parameter logic [31:0] EXPECTED_TS    = DefaultExpectedTs,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        mismatch,
   output logic        timeout,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   sysid_state_e state_q, state_d;

   logic        auto_q;
   logic        id_ok_q, mismatch_q, timeout_q;
   logic [31:0] cap_id_q, cap_ts_q;

   logic read_active;
   logic timer_clear;
   logic timer_stall;
   logic stall_expired;
   logic words_match;

   assign read_active = is_read_state(state_q);
   // Any state change restarts the count, so each read state sees a fresh counter
   assign timer_clear = (state_d != state_q) || !read_active;
   assign timer_stall = read_active && avm_waitrequest;
   assign words_match = (cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TS);

   system_0_stall_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_stall_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .stall   (timer_stall),
      .expired (stall_expired)
   );

   always_comb begin
      state_d     = state_q;
      avm_read    = 1'b0;
      avm_address = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (auto_q || start) begin
               state_d = StRdId;
            end
         end
         StRdId: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               state_d = StRdTs;
            end else if (stall_expired) begin
               state_d = StFin;
            end
         end
         StRdTs: begin
            avm_read    = 1'b1;
            avm_address = 1'b1;
            if (!avm_waitrequest) begin
               state_d = StCmp;
            end else if (stall_expired) begin
               state_d = StFin;
            end
         end
         StCmp: begin
            state_d = StFin;
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         auto_q     <= 1'b1;
         id_ok_q    <= 1'b0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
         cap_id_q   <= '0;
         cap_ts_q   <= '0;
      end else begin
         state_q <= state_d;
         // Power-on check request is consumed by the first IDLE cycle after reset
         auto_q  <= 1'b0;

         if ((state_q == StRdId) && !avm_waitrequest) begin
            cap_id_q <= avm_readdata;
         end
         if ((state_q == StRdTs) && !avm_waitrequest) begin
            cap_ts_q <= avm_readdata;
         end

         if ((state_q == StIdle) && (state_d == StRdId)) begin
            id_ok_q    <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
         end else if (read_active && stall_expired) begin
            id_ok_q    <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b1;
         end else if (state_q == StCmp) begin
            id_ok_q    <= words_match;
            mismatch_q <= !words_match;
            timeout_q  <= 1'b0;
         end
      end
   end

   assign id_ok       = id_ok_q;
   assign mismatch    = mismatch_q;
   assign timeout     = timeout_q;
   assign captured_id = cap_id_q;
   assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Scoreboard bench for system_0_sysid_checker: a behavioural sysid slave with
// programmable stalls, expected results queued per check and popped on done.
module tb_system_0_sysid_checker;

   localparam int unsigned Timeout = 4;
   localparam logic [31:0] GoodId  = 32'd0;
   localparam logic [31:0] GoodTs  = 32'd1671495253;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        mismatch;
   logic        timeout;
   logic [31:0] captured_id;
   logic [31:0] captured_ts;

   system_0_sysid_checker #(
      .TIMEOUT_CYCLES (Timeout)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .busy            (busy),
      .done            (done),
      .id_ok           (id_ok),
      .mismatch        (mismatch),
      .timeout         (timeout),
      .captured_id     (captured_id),
      .captured_ts     (captured_ts)
   );

   always #5 clock = ~clock;

   // Behavioural slave: stalls wait_cfg cycles per read, or forever when stuck
   int          wait_cfg = 0;
   logic        stuck    = 1'b0;
   logic [31:0] id_val   = GoodId;
   logic [31:0] ts_val   = GoodTs;
   int          st_cnt   = 0;

   always @(posedge clock) begin
      if (avm_read && avm_waitrequest) st_cnt <= st_cnt + 1;
      else st_cnt <= 0;
   end

   assign avm_waitrequest = stuck | (avm_read & (st_cnt < wait_cfg));
   assign avm_readdata    = avm_address ? ts_val : id_val;

   int   cyc      = 0;
   logic rst_seen = 1'b0;
   always @(posedge clock) begin
      cyc      <= cyc + 1;
      rst_seen <= !reset_n;
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] cid;
      logic [31:0] cts;
      logic [2:0]  flags;
      int          done_cyc;
      int          rd_cycles;
      int          ts_cycles;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [31:0] m_cid = '0;
   logic [31:0] m_cts = '0;

   // Called right after a negedge on which the check request is presented
   task automatic expect_check(input int waits, input logic stall_out);
      exp_t e;
      if (stall_out) begin
         e.cid       = m_cid;
         e.cts       = m_cts;
         e.flags     = 3'b001;
         e.done_cyc  = cyc + 1 + Timeout;
         e.rd_cycles = Timeout;
         e.ts_cycles = 0;
      end else begin
         m_cid       = id_val;
         m_cts       = ts_val;
         e.cid       = id_val;
         e.cts       = ts_val;
         e.flags     = (id_val == GoodId && ts_val == GoodTs) ? 3'b100 : 3'b010;
         e.done_cyc  = cyc + 4 + 2 * waits;
         e.rd_cycles = 2 + 2 * waits;
         e.ts_cycles = 1 + waits;
      end
      sb_q.push_back(e);
   endtask

   task automatic pulse_start(input int waits, input logic stall_out);
      @(negedge clock);
      start = 1'b1;
      expect_check(waits, stall_out);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         if (sb_q.size() == 0) break;
      end
      check_eq("done_seen", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
      repeat (3) @(negedge clock);
   endtask

   // Monitor
   int   rd_cnt     = 0;
   int   ts_cnt     = 0;
   logic read_prev  = 1'b0;
   logic stall_prev = 1'b0;
   logic addr_prev  = 1'b0;
   logic done_prev  = 1'b0;

   always @(negedge clock) begin
      if (rst_seen) begin
         check_eq("rst_ctrl", {57'd0, busy, done, id_ok, mismatch, timeout, avm_read,
                               avm_address}, 64'd0);
         check_eq("rst_capt", {captured_id, captured_ts}, 64'd0);
         rd_cnt    = 0;
         ts_cnt    = 0;
         read_prev = 1'b0;
         done_prev = 1'b0;
      end else begin
         if (avm_read) begin
            rd_cnt++;
            if (avm_address) ts_cnt++;
         end
         if (avm_read && !read_prev) begin
            check_eq("flags_clr_at_rd_id", {61'd0, id_ok, mismatch, timeout}, 64'd0);
            check_eq("first_addr", {63'd0, avm_address}, 64'd0);
         end
         if (avm_read && read_prev && stall_prev)
            check_eq("addr_stable", {63'd0, avm_address}, {63'd0, addr_prev});
         if (done) begin
            if (sb_q.size() == 0) begin
               check_eq("spurious_done", {63'd0, done}, 64'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
               check_eq("flags", {61'd0, id_ok, mismatch, timeout}, {61'd0, mon_e.flags});
               check_eq("captured_id", {32'd0, captured_id}, {32'd0, mon_e.cid});
               check_eq("captured_ts", {32'd0, captured_ts}, {32'd0, mon_e.cts});
               check_eq("read_cycles", 64'(rd_cnt), 64'(mon_e.rd_cycles));
               check_eq("ts_cycles", 64'(ts_cnt), 64'(mon_e.ts_cycles));
               check_eq("busy_at_done", {63'd0, busy}, 64'd1);
            end
            rd_cnt = 0;
            ts_cnt = 0;
         end
         if (done_prev) check_eq("idle_after_done", {63'd0, busy}, 64'd0);
         read_prev  = avm_read;
         stall_prev = avm_waitrequest;
         addr_prev  = avm_address;
         done_prev  = done;
      end
   end

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      repeat (3) @(negedge clock);

      // Auto-check after reset release, zero-wait good slave
      reset_n = 1'b1;
      expect_check(0, 1'b0);
      wait_idle();

      // Timestamp off by one
      ts_val = GoodTs - 32'd1;
      pulse_start(0, 1'b0);
      wait_idle();

      // Three stall cycles on each read
      ts_val   = GoodTs;
      wait_cfg = 3;
      pulse_start(3, 1'b0);
      wait_idle();
      wait_cfg = 0;

      // Slave stuck: abort after Timeout stalled cycles, captures retained
      stuck = 1'b1;
      pulse_start(0, 1'b1);
      wait_idle();
      stuck = 1'b0;

      // Wrong ID; start re-pulsed in RD_ID, CMP and FIN must be ignored
      id_val = 32'h0000_0001;
      @(negedge clock);
      start = 1'b1;
      expect_check(0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
      wait_idle();
      repeat (6) @(negedge clock);

      // Reset pulse during RD_TS abandons the check; fresh auto-check follows
      id_val   = GoodId;
      wait_cfg = 2;
      pulse_start(2, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (avm_read && avm_address) break;
         @(negedge clock);
      end
      check_eq("reach_rd_ts", {63'd0, avm_read && avm_address}, 64'd1);
      reset_n = 1'b0;
      sb_q.delete();
      m_cid = '0;
      m_cts = '0;
      @(negedge clock);
      reset_n  = 1'b1;
      wait_cfg = 0;
      expect_check(0, 1'b0);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/system_0_sysid_checker.md
SYSTEM_0_SYSID_CHECKER -- requirements
Module: system_0_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, system ID value required at slave word 0.
REQ-002 Parameter EXPECTED_TS, default 1671495253, timestamp value required at slave word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535; maximum stalled cycles per read before abort.
REQ-004 clock  in  1  single system clock; all logic rising-edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; requests a re-check.
REQ-007 avm_address  out  1  sysid word select: 0 = ID, 1 = timestamp.
REQ-008 avm_read  out  1  Avalon-MM read strobe to the sysid slave.
REQ-009 avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave.
REQ-010 avm_readdata  in  32  slave read data; valid when avm_read=1 and avm_waitrequest=0.
REQ-011 busy  out  1  check sequence in progress.
REQ-012 done  out  1  one-cycle pulse at the end of each check.
REQ-013 id_ok  out  1  last check matched both words.
REQ-014 mismatch  out  1  last check completed with a mismatched word.
REQ-015 timeout  out  1  last check aborted on stall timeout.
REQ-016 captured_id  out  32  word 0 from the last check.
REQ-017 captured_ts  out  32  word 1 from the last check.

Function
REQ-018 FSM states SHALL be: IDLE, RD_ID, RD_TS, CMP, FIN.
REQ-019 The first cycle after reset release SHALL enter RD_ID; no start pulse is required.
REQ-020 In IDLE, start=1 SHALL enter RD_ID on the next cycle; start SHALL be ignored in every other state.
REQ-021 RD_ID SHALL drive avm_read=1, avm_address=0, and hold both until a cycle with avm_waitrequest=0, in which captured_id<=avm_readdata and the FSM enters RD_TS.
REQ-022 RD_TS SHALL behave identically with avm_address=1, capture into captured_ts, and enter CMP.
REQ-023 avm_read SHALL be 0 in IDLE, CMP, and FIN, and avm_address SHALL be 0 there.
REQ-024 A 16-bit stall counter SHALL clear on entry to each read state and increment on each cycle with avm_waitrequest=1.
REQ-025 When the counter reaches TIMEOUT_CYCLES while avm_waitrequest=1, the FSM SHALL drop avm_read next cycle, set timeout=1, id_ok=0, and mismatch=0, and go to FIN; already-captured words are retained.
REQ-026 CMP SHALL set id_ok=1 if captured_id==EXPECTED_ID and captured_ts==EXPECTED_TS; otherwise mismatch=1; timeout=0; go to FIN.
REQ-027 FIN SHALL pulse done=1 for exactly one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in RD_ID, RD_TS, CMP, and FIN, and 0 in IDLE.
REQ-029 id_ok, mismatch, and timeout SHALL be cleared on entry to RD_ID and SHALL hold the result from FIN until the next check; at most one of the three SHALL be 1.
REQ-030 Zero-wait latency: start in IDLE at cycle N gives RD_ID at N+1, RD_TS at N+2, CMP at N+3, and done at N+4.
REQ-031 Result registers SHALL update only in CMP or on timeout.

Reset
REQ-032 With reset_n=0 at a clock edge: FSM<=IDLE, with RD_ID taken after release; all outputs 0, including captured_id and captured_ts.
REQ-033 Reset asserted mid-read SHALL drop avm_read on the next edge and abandon the transfer without a done pulse.

Structure
REQ-034 FSM state enumeration and the default EXPECTED_ID/EXPECTED_TS constants SHALL live in a shared package, system_0_sysid_pkg.
REQ-035 A single optional sub-module, system_0_stall_timer (stall counter with terminal flag), is natural; otherwise the block is flat.

Verification
REQ-036 Zero-wait slave returning 0 and 1671495253; release reset -> reads at addresses 0 then 1, done at the 4th cycle after release, id_ok=1, captured_ts=1671495253.
REQ-037 Slave returns 1671495252 at word 1 -> mismatch=1, id_ok=0, timeout=0, captured_ts=1671495252.
REQ-038 waitrequest held 3 cycles on each read -> address and read stable throughout, done 6 cycles later than the zero-wait case, id_ok=1.
REQ-039 TIMEOUT_CYCLES=4 with waitrequest stuck at 1 -> read deasserts after the 4th stalled cycle, timeout=1, one done pulse, FSM back in IDLE.
REQ-040 After a completed check, start pulse -> new sequence with flags cleared at RD_ID; start pulsed again while busy -> ignored, exactly one done.
REQ-041 reset_n=0 for 1 cycle during RD_TS -> avm_read=0 next edge, all outputs 0, no done, fresh auto-check after release.
